// File: rtl/rc5_decryption.sv
// Iterative RC5-32/R block decipher, one round per clock.
// Ready/valid on both sides, subkey table loadable only while idle.
module rc5_decryption #(
    parameter int ROUNDS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sk_we,
    input  logic [4:0]  sk_addr,
    input  logic [31:0] sk_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] d_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] d_out
);

    localparam int NK = 2 * ROUNDS + 2;
    localparam logic [4:0] LAST = 5'(2 * ROUNDS + 1);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t      state_q;
    logic [3:0]  i_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [63:0] d_out_q;
    logic [31:0] s_q [NK];

    logic [31:0] a_d;
    logic [31:0] b_d;
    logic [4:0]  idx_a;
    logic [4:0]  idx_b;

    function automatic logic [31:0] ror(input logic [31:0] x,
                                        input logic [4:0]  n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    always_comb begin
        idx_a = {i_q, 1'b0};
        idx_b = {i_q, 1'b1};
        b_d   = ror(b_q - s_q[idx_b], a_q[4:0]) ^ a_q;
        a_d   = ror(a_q - s_q[idx_a], b_d[4:0]) ^ b_d;
    end

    // Key table has no reset; writes only land while idle so a block
    // in flight always sees one consistent key set.
    always_ff @(posedge clk) begin
        if (sk_we && state_q == IDLE && sk_addr <= LAST) begin
            s_q[sk_addr] <= sk_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            d_out_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        a_q        <= d_in[31:0];
                        b_q        <= d_in[63:32];
                        i_q        <= 4'(ROUNDS);
                        in_ready_q <= 1'b0;
                        state_q    <= ROUND;
                    end
                end
                ROUND: begin
                    a_q <= a_d;
                    b_q <= b_d;
                    i_q <= i_q - 4'd1;
                    if (i_q == 4'd1) begin
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    d_out_q     <= {b_q - s_q[1], a_q - s_q[0]};
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d_out     = d_out_q;

endmodule
